// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one dataMem port between the CPU
// load/store path and a DMA/program-loader requester. It has DMA starvation
// protection and a bounded DMA lock mode for bursts.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_wrType,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic              dma_we,
    input  logic [3:0]        dma_wrType,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wrType,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     starve_cnt, starve_nxt;
    logic [LW-1:0]     lock_cnt, lock_nxt, lock_inc;
    logic              cpu_rd_q, dma_rd_q;
    logic [DATA_W-1:0] cpu_hold, dma_hold;

    // Grant selection, lock/starvation bookkeeping and next-state logic
    always_comb begin
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        state_nxt  = state;
        lock_nxt   = lock_cnt;
        starve_nxt = starve_cnt;
        lock_inc   = lock_cnt + LW'(1);
        case (state)
            ARB: begin
                if (dma_req && (!cpu_req || starve_cnt == SW'(STARVE_MAX)))
                    dma_gnt = 1'b1;
                else if (cpu_req)
                    cpu_gnt = 1'b1;
                // The grant that opens a burst counts toward the lock budget
                if (dma_gnt && dma_lock && lock_inc != LW'(LOCK_MAX)) begin
                    state_nxt = LOCK;
                    lock_nxt  = lock_inc;
                end
            end
            LOCK: begin
                if (dma_req)
                    dma_gnt = 1'b1;
                else if (cpu_req)
                    cpu_gnt = 1'b1;
                if (!dma_lock || !dma_req || lock_inc == LW'(LOCK_MAX)) begin
                    state_nxt = ARB;
                    lock_nxt  = '0;
                end else begin
                    lock_nxt  = lock_inc;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (!dma_req || dma_gnt)
            starve_nxt = '0;
        else if (starve_cnt != SW'(STARVE_MAX))
            starve_nxt = starve_cnt + SW'(1);
    end

    // Memory port drive from the current winner; idle port is all zeros
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wrType = '0;
        mem_rd     = 1'b0;
        if (cpu_gnt) begin
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            mem_wrType = cpu_we ? cpu_wrType : 4'b0000;
            mem_rd     = ~cpu_we;
        end else if (dma_gnt) begin
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            mem_wrType = dma_we ? dma_wrType : 4'b0000;
            mem_rd     = ~dma_we;
        end
    end

    // Arbiter state, counters, read-owner tags and held read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            cpu_rd_q   <= 1'b0;
            dma_rd_q   <= 1'b0;
            cpu_hold   <= '0;
            dma_hold   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lock_cnt   <= lock_nxt;
            cpu_rd_q   <= cpu_gnt & ~cpu_we;
            dma_rd_q   <= dma_gnt & ~dma_we;
            if (cpu_rd_q) cpu_hold <= mem_rdata;
            if (dma_rd_q) dma_hold <= mem_rdata;
        end
    end

    // Read data arrives the cycle after mem_rd; forward it to the owner,
    // and the other side keeps showing its last returned word
    always_comb begin
        cpu_stall  = cpu_req & ~cpu_gnt;
        cpu_rvalid = cpu_rd_q;
        dma_rvalid = dma_rd_q;
        cpu_rdata  = cpu_rd_q ? mem_rdata : cpu_hold;
        dma_rdata  = dma_rd_q ? mem_rdata : dma_hold;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus read-return scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_lock, dma_we;
    logic [3:0]  cpu_wrType, dma_wrType;
    logic [11:0] cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_rd;
    logic [31:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wrType;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        creq, cwe;
        logic [3:0]  cwt;
        logic [11:0] caddr;
        logic [31:0] cwd;
        logic        dreq, dlock, dwe;
        logic [3:0]  dwt;
        logic [11:0] daddr;
        logic [31:0] dwd;
        logic        ecg, edg;
    } vec_t;

    typedef struct {
        logic        owner_dma;
        logic [31:0] data;
    } rd_t;

    vec_t        tbl[$];
    rd_t         sb[$];
    logic [31:0] exp_chold = '0;
    logic [31:0] exp_dhold = '0;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4), .LOCK_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wrType(cpu_wrType),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_wrType(dma_wrType),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrType(mem_wrType),
        .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the bench
    function automatic logic [31:0] mf(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
    endfunction

    // dataMem stand-in: read data valid the cycle after mem_rd
    always @(posedge clk) if (mem_rd) mem_rdata <= mf(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [3:0] cwt,
                                input logic [11:0] caddr, input logic [31:0] cwd,
                                input logic dreq, input logic dlock, input logic dwe,
                                input logic [3:0] dwt, input logic [11:0] daddr,
                                input logic [31:0] dwd, input logic ecg, input logic edg);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.cwt = cwt; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dlock = dlock; v.dwe = dwe; v.dwt = dwt; v.daddr = daddr; v.dwd = dwd;
        v.ecg = ecg; v.edg = edg;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 4'h0, 12'h0, 32'h0, 0, 0, 0, 4'h0, 12'h0, 32'h0, 0, 0);
    endfunction

    // One cycle: drive, check at negedge, record expected read returns
    task automatic step(input vec_t v);
        rd_t         r;
        logic        exp_crv, exp_drv, erd;
        logic [3:0]  ewt;
        logic [11:0] eaddr;
        logic [31:0] ewd;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_wrType = v.cwt; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dma_req = v.dreq; dma_lock = v.dlock; dma_we = v.dwe; dma_wrType = v.dwt;
        dma_addr = v.daddr; dma_wdata = v.dwd;
        @(negedge clk);
        exp_crv = 1'b0;
        exp_drv = 1'b0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.owner_dma) begin exp_drv = 1'b1; exp_dhold = r.data; end
            else             begin exp_crv = 1'b1; exp_chold = r.data; end
        end
        chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, exp_crv});
        chk("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, exp_drv});
        chk("cpu_rdata", cpu_rdata, exp_chold);
        chk("dma_rdata", dma_rdata, exp_dhold);
        chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, v.ecg});
        chk("dma_gnt", {31'b0, dma_gnt}, {31'b0, v.edg});
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, v.creq & ~v.ecg});
        eaddr = '0; ewd = '0; ewt = '0; erd = 1'b0;
        if (v.ecg) begin
            eaddr = v.caddr; ewd = v.cwd; ewt = v.cwe ? v.cwt : 4'h0; erd = ~v.cwe;
        end else if (v.edg) begin
            eaddr = v.daddr; ewd = v.dwd; ewt = v.dwe ? v.dwt : 4'h0; erd = ~v.dwe;
        end
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, erd});
        chk("mem_wrType", {28'b0, mem_wrType}, {28'b0, ewt});
        chk("mem_addr", {20'b0, mem_addr}, {20'b0, eaddr});
        chk("mem_wdata", mem_wdata, ewd);
        if (v.ecg && !v.cwe) sb.push_back('{1'b0, mf(v.caddr)});
        if (v.edg && !v.dwe) sb.push_back('{1'b1, mf(v.daddr)});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_gnt"}, {31'b0, cpu_gnt}, 32'h0);
        chk({tag, "_dma_gnt"}, {31'b0, dma_gnt}, 32'h0);
        chk({tag, "_cpu_rvalid"}, {31'b0, cpu_rvalid}, 32'h0);
        chk({tag, "_dma_rvalid"}, {31'b0, dma_rvalid}, 32'h0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        chk({tag, "_dma_rdata"}, dma_rdata, 32'h0);
        chk({tag, "_mem_rd"}, {31'b0, mem_rd}, 32'h0);
        chk({tag, "_mem_wrType"}, {28'b0, mem_wrType}, 32'h0);
        chk({tag, "_mem_addr"}, {20'b0, mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        vec_t v;
        // Vector table, applied in order from a clean reset
        tbl.push_back(mk(1, 0, 4'h0, 12'h010, 32'h0, 0, 0, 0, 4'h0, 12'h0, 32'h0, 1, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(0, 0, 4'h0, 12'h0, 32'h0, 1, 0, 1, 4'b0011, 12'h020, 32'h55667788, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 12'h0, 32'h0, 1, 0, 0, 4'h0, 12'h021, 32'h0, 0, 1));
        tbl.push_back(idle());
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 0, 4'h0, 12'h030 + 12'(i), 32'h0, 1, 0, 0, 4'h0, 12'h040 + 12'(i),
                             32'h0, (i % 5) != 4, (i % 5) == 4));
        tbl.push_back(mk(1, 1, 4'hF, 12'h050, 32'h11223344, 1, 0, 1, 4'b0001, 12'h050, 32'hAABBCCDD, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 12'h0, 32'h0, 1, 0, 1, 4'b0001, 12'h050, 32'hAABBCCDD, 0, 1));
        tbl.push_back(idle());

        v = idle();
        cpu_req = 0; cpu_we = 0; cpu_wrType = '0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_wrType = '0; dma_addr = '0; dma_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Reset lands between a CPU load grant and its return
        cpu_req = 1'b1; cpu_addr = 12'h010;
        @(negedge clk);
        chk("midrd_cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        chk("midrd_mem_rd", {31'b0, mem_rd}, 32'h1);
        #2;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrd");
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // Locked burst against a persistent CPU request
        for (int i = 0; i < 13; i++)
            step(mk(1, 0, 4'h0, 12'h060 + 12'(i), 32'h0, 1, 1, 0, 4'h0, 12'h070 + 12'(i), 32'h0,
                    (i < 4) || (i == 12), (i >= 4) && (i < 12)));
        step(idle());
        step(idle());
        chk("sb_drained", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
